serial_asbc_responder: RTL and testbench
========================================

// Module: serial_asbc_responder
// PURPOSE
//  Request/response execution unit for the add/sub/bitwise/compare operation set.
//  - Accepts one operation request on a valid/ready port.
//  - Executes it bit-serially, LSB first, one bit per clock.
//  - Returns the result on a second valid/ready port.
//  Sits between a command issuer and the 8-bit ALU datapath; it trades latency for area and registers every output.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  req_valid   in   1      request present
//  req_ready   out  1      unit can accept a request
//  req_sel     in   2      00 add, 01 sub, 10 bitwise XOR, 11 compare
//  req_a       in   WIDTH  operand a
//  req_b       in   WIDTH  operand b
//  rsp_valid   out  1      response present
//  rsp_ready   in   1      consumer takes response
//  rsp_result  out  WIDTH  add/sub/XOR result; 0 for compare
//  rsp_cout    out  1      add: carry out; sub: 1 = no borrow (a>=b); else 0
//  rsp_gt      out  1      compare: a>b; 0 for other ops
//  rsp_eq      out  1      compare: a==b; 0 for other ops
//  rsp_lt      out  1      compare: a<b; 0 for other ops
// BEHAVIOUR
//  Reset: async, active-high. State=IDLE, bit counter=0. All rsp_* outputs=0; req_ready=0 while rst is high.
//  FSM states: IDLE, EXEC, DONE.
//  - IDLE: req_ready=1. On an edge with req_valid&&req_ready, latch sel/a/b and go to EXEC with bit index 0.
//    - Initial carry = (sel==01). b is inverted for sub, so sub computes a+~b+1.
//    - Compare flags are initialised to gt=0, lt=0.
//  - EXEC: req_ready=0. Each edge processes bit i and increments i.
//    - add/sub: sum_i=a_i^b'_i^c; c=majority(a_i,b'_i,c).
//    - xor: r_i=a_i^b_i.
//    - compare: when a_i!=b_i, set gt=a_i, lt=~a_i. Later (more significant) bits override earlier ones.
//    - The edge that processes bit WIDTH-1 goes to DONE.
//  - DONE: rsp_valid=1. All rsp_* fields are registered and held stable until accepted.
//    - eq=~gt&~lt for compare. Unused fields are 0.
//    - On an edge with rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid.
//  Latency: rsp_valid rises exactly WIDTH clocks after the request-accept edge. Throughput: one op per WIDTH+2 clocks minimum.
//  No bypass: req_ready rises only in the cycle after the response handshake. A request never overlaps a pending response.
//  Request inputs are ignored outside IDLE. Operands are captured at accept, so later changes to req_* have no effect.
//  rsp_ready low in DONE: hold all outputs indefinitely. rsp_ready high outside DONE: no effect.
//  Carry is WIDTH-bit modular: result = (a op b) mod 2^WIDTH, and the carry/borrow appears only in rsp_cout.
//  Reset mid-EXEC or mid-DONE: the operation is abandoned with no response. After rst falls, req_ready=1 in the first cycle.
// TESTING (WIDTH=8)
//  1. add a=C8 b=64: rsp_valid 8 clk after accept; result=2C, cout=1, gt/eq/lt=0.
//  2. sub a=05 b=07: result=FE, cout=0. Then sub a=07 b=05: result=02, cout=1.
//  3. xor a=F0 b=3C: result=CC, cout=0. Compare a=80 b=7F: gt=1, eq=0, lt=0, result=00.
//     Compare a=5A b=5A: eq=1. Compare a=01 b=02: lt=1.
//  4. Backpressure: hold rsp_ready=0 for 5 clk in DONE. Outputs stay stable and req_ready stays 0.
//     Change req_a mid-EXEC: result is unchanged.
//  5. Back-to-back: req_valid held high with rsp_ready=1. Second accept occurs 1 clk after the first response handshake.
//  6. Assert rst at bit 4 of an add. All outputs drop to 0 asynchronously. No rsp_valid appears.
//     req_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/serial_asbc_responder_if.sv
// Request/response bundle for the bit-serial add/sub/xor/compare unit.
// The master issues requests and consumes responses; the slave is the execution unit.
interface serial_asbc_responder_if #(parameter int WIDTH = 8);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_sel;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_cout;
   logic             rsp_gt;
   logic             rsp_eq;
   logic             rsp_lt;

   modport master (
      output req_valid, req_sel, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_gt, rsp_eq, rsp_lt
   );

   modport slave (
      input  req_valid, req_sel, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_gt, rsp_eq, rsp_lt
   );
endinterface

// File: rtl/serial_asbc_responder.sv
// Bit-serial execution unit: accepts one add/sub/xor/compare request, walks the
// operands LSB first (one bit per clock), then holds a registered response until taken.
module serial_asbc_responder #(
   parameter int WIDTH = 8
) (
   input logic                    clk,
   input logic                    rst,
   serial_asbc_responder_if.slave bus
);

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_CMP = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t state, state_next;

   logic [IW-1:0]    bit_idx;
   logic [1:0]       op;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic             carry, gt_f, lt_f;

   logic             rsp_valid_q, rsp_cout_q, rsp_gt_q, rsp_eq_q, rsp_lt_q;
   logic [WIDTH-1:0] rsp_result_q;

   logic             accept, rsp_take, last_bit;
   logic             a_i, b_i, r_bit, carry_n, gt_n, lt_n;
   logic [WIDTH-1:0] res_full;

   assign bus.req_ready  = (state == IDLE) && !rst;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_cout   = rsp_cout_q;
   assign bus.rsp_gt     = rsp_gt_q;
   assign bus.rsp_eq     = rsp_eq_q;
   assign bus.rsp_lt     = rsp_lt_q;

   assign accept   = bus.req_valid && (state == IDLE);
   assign rsp_take = rsp_valid_q && bus.rsp_ready;
   assign last_bit = (bit_idx == LAST_IDX);

   // One full-adder / comparator slice evaluated on the current LSBs of the shifters.
   always_comb begin
      a_i      = a_sh[0];
      b_i      = b_sh[0];
      carry_n  = (a_i & b_i) | (a_i & carry) | (b_i & carry);
      r_bit    = (op == OP_XOR) ? (a_i ^ b_i) : (a_i ^ b_i ^ carry);
      gt_n     = gt_f;
      lt_n     = lt_f;
      if (a_i != b_i) begin
         gt_n = a_i;
         lt_n = ~a_i;
      end
      res_full = {r_bit, res_sh[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)   state_next = EXEC;
         EXEC:    if (last_bit) state_next = DONE;
         DONE:    if (rsp_take) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand shifters and response registers; sub is done as a + ~b + 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_idx      <= '0;
         op           <= OP_ADD;
         a_sh         <= '0;
         b_sh         <= '0;
         res_sh       <= '0;
         carry        <= 1'b0;
         gt_f         <= 1'b0;
         lt_f         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_cout_q   <= 1'b0;
         rsp_gt_q     <= 1'b0;
         rsp_eq_q     <= 1'b0;
         rsp_lt_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op      <= bus.req_sel;
                  a_sh    <= bus.req_a;
                  b_sh    <= (bus.req_sel == OP_SUB) ? ~bus.req_b : bus.req_b;
                  carry   <= (bus.req_sel == OP_SUB);
                  res_sh  <= '0;
                  gt_f    <= 1'b0;
                  lt_f    <= 1'b0;
                  bit_idx <= '0;
               end
            end
            EXEC: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               res_sh  <= res_full;
               carry   <= carry_n;
               gt_f    <= gt_n;
               lt_f    <= lt_n;
               bit_idx <= bit_idx + 1'b1;
               if (last_bit) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_result_q <= (op == OP_CMP) ? '0 : res_full;
                  rsp_cout_q   <= ((op == OP_ADD) || (op == OP_SUB)) ? carry_n : 1'b0;
                  rsp_gt_q     <= (op == OP_CMP) ? gt_n : 1'b0;
                  rsp_lt_q     <= (op == OP_CMP) ? lt_n : 1'b0;
                  rsp_eq_q     <= (op == OP_CMP) ? (~gt_n & ~lt_n) : 1'b0;
               end
            end
            DONE: begin
               if (rsp_take) begin
                  rsp_valid_q  <= 1'b0;
                  rsp_result_q <= '0;
                  rsp_cout_q   <= 1'b0;
                  rsp_gt_q     <= 1'b0;
                  rsp_eq_q     <= 1'b0;
                  rsp_lt_q     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_asbc_responder.sv
// Randomized and directed bench for serial_asbc_responder, checked against an
// arithmetic reference model of the four operations.
module tb_serial_asbc_responder;

   localparam int W = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   serial_asbc_responder_if #(.WIDTH(W)) bus ();

   serial_asbc_responder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference packs {result, cout, gt, eq, lt} from plain integer arithmetic.
   function automatic logic [W+3:0] model(input logic [1:0] sel, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      int unsigned ai, bi, s;
      logic [W-1:0] r;
      logic cout, gt, eq, lt;
      ai = a; bi = b;
      r = '0; cout = 0; gt = 0; eq = 0; lt = 0;
      case (sel)
         2'b00: begin s = ai + bi; r = W'(s % 256); cout = (s >= 256); end
         2'b01: begin s = (ai + 256 - bi) % 256; r = W'(s); cout = (ai >= bi); end
         2'b10: r = a ^ b;
         default: begin gt = (ai > bi); eq = (ai == bi); lt = (ai < bi); end
      endcase
      return {r, cout, gt, eq, lt};
   endfunction

   function automatic logic [W+3:0] rspVec();
      return {bus.rsp_result, bus.rsp_cout, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Issues one request, checks latency and response, optionally stalls and
   // scrambles the request bus mid-execution, then completes the handshake.
   task automatic applyStimulus(input logic [1:0] sel, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int stall, input bit scramble);
      logic rdy;
      logic [W+3:0] held;
      int lat;
      bit ok;
      bus.req_valid = 1'b1;
      bus.req_sel   = sel;
      bus.req_a     = a;
      bus.req_b     = b;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         rdy = bus.req_ready;
         @(posedge clk); #1;
         if (rdy) begin ok = 1; break; end
      end
      bus.req_valid = 1'b0;
      if (!ok) begin
         checkOutput("accept_timeout", 32'(0), 32'(1));
         return;
      end
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
         if (scramble && lat == 3) begin
            bus.req_a   = W'($urandom);
            bus.req_b   = W'($urandom);
            bus.req_sel = 2'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(W));
      if (!bus.rsp_valid) return;
      checkOutput("rsp_fields", 32'(rspVec()), 32'(model(sel, a, b)));
      checkOutput("ready_in_done", 32'(bus.req_ready), 32'(0));
      held = rspVec();
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_fields", 32'(rspVec()), 32'(held));
         checkOutput("hold_valid", 32'(bus.rsp_valid), 32'(1));
         checkOutput("hold_ready", 32'(bus.req_ready), 32'(0));
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      checkOutput("valid_cleared", 32'(bus.rsp_valid), 32'(0));
      checkOutput("ready_after_take", 32'(bus.req_ready), 32'(1));
   endtask

   initial begin
      int acc1, acc2, hs1, cyc;
      bit sawValid;
      logic [1:0] rs;
      logic [W-1:0] ra, rb;
      checks = 0; failures = 0;
      bus.req_valid = 0; bus.req_sel = 0; bus.req_a = 0; bus.req_b = 0; bus.rsp_ready = 0;
      rst = 1'b1;
      #12;
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'(0));
      checkOutput("reset_rsp", 32'({bus.rsp_valid, rspVec()}), 32'(0));
      @(negedge clk); rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 32'(bus.req_ready), 32'(1));
      @(posedge clk); #1;

      applyStimulus(2'b00, 8'hC8, 8'h64, 0, 0);
      applyStimulus(2'b01, 8'h05, 8'h07, 0, 0);
      applyStimulus(2'b01, 8'h07, 8'h05, 0, 0);
      applyStimulus(2'b10, 8'hF0, 8'h3C, 0, 0);
      applyStimulus(2'b11, 8'h80, 8'h7F, 0, 0);
      applyStimulus(2'b11, 8'h5A, 8'h5A, 0, 0);
      applyStimulus(2'b11, 8'h01, 8'h02, 0, 0);
      applyStimulus(2'b00, 8'hFF, 8'h01, 5, 1);
      applyStimulus(2'b01, 8'h00, 8'h00, 2, 1);

      for (int n = 0; n < 24; n++) begin
         rs = 2'($urandom);
         ra = W'($urandom);
         rb = (n % 6 == 0) ? ra : W'($urandom);
         applyStimulus(rs, ra, rb, int'($urandom_range(0, 3)), 1'($urandom));
      end

      // Back-to-back with both sides always willing.
      bus.req_sel = 2'b00; bus.req_a = 8'h33; bus.req_b = 8'h44;
      bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
      acc1 = -1; acc2 = -1; hs1 = -1;
      for (cyc = 0; cyc < 30; cyc++) begin
         if (bus.req_ready && bus.req_valid) begin
            if (acc1 < 0) acc1 = cyc; else if (acc2 < 0) acc2 = cyc;
         end
         if (bus.rsp_valid && bus.rsp_ready && hs1 < 0) begin
            hs1 = cyc;
            checkOutput("b2b_result", 32'(rspVec()), 32'(model(2'b00, 8'h33, 8'h44)));
         end
         @(posedge clk); #1;
      end
      checkOutput("b2b_accept_gap", 32'(acc2 - acc1), 32'(W + 2));
      checkOutput("b2b_after_handshake", 32'(acc2 - hs1), 32'(1));
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
      rst = 1'b1; #3; rst = 1'b0;
      @(posedge clk); #1;

      // Abandon an add midway through with an asynchronous reset.
      bus.req_sel = 2'b00; bus.req_a = 8'hC8; bus.req_b = 8'h64; bus.req_valid = 1'b1;
      for (int i = 0; i < 20 && !bus.req_ready; i++) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("async_rst_outputs", 32'({bus.req_ready, bus.rsp_valid, rspVec()}), 32'(0));
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      checkOutput("ready_first_cycle", 32'(bus.req_ready), 32'(1));
      bus.rsp_ready = 1'b1;
      sawValid = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) sawValid = 1;
      end
      checkOutput("no_rsp_after_abort", 32'(sawValid), 32'(0));
      bus.rsp_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
